// File: rtl/core_fetch.sv
// core_fetch: instruction fetch front end with a small prefetch queue.
//
// Issues one halfword request at a time to instruction memory, buffers the
// responses in a FIFO and presents the oldest one to decode. Flush redirects
// the fetch PC and throws away everything in flight.
//
// Build option CORE_FETCH_PREFETCH_EN: when defined, the queue holds DEPTH
// entries. When undefined, the queue is a single entry and a new request is
// only issued once that entry has left the queue.
//
// Handshakes:
//   memory request : fetch_start/fetch_addr are held until fetch_ready=1
//                    (accept on fetch_start & fetch_ready). A flush withdraws
//                    an unaccepted request. fetch_valid returns the response
//                    to the single accepted, unanswered request.
//   decode         : insn/insn_pc are valid whenever the queue is non-empty;
//                    the head is consumed on any cycle with stall=0.
//
// An empty queue presents `NOP at pc 0.

`ifndef NOP
`define NOP 16'h0001
`endif

module core_fetch #(
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] target,
  output logic              fetch_start,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ready,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] fetch_data,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              dbg_state
);

`ifdef CORE_FETCH_PREFETCH_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  localparam int PTR_W = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int CNT_W = $clog2(CAP + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(CAP - 1);
  localparam logic [CNT_W-1:0] CNT_CAP   = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] CNT_CAP_1 = CNT_W'(CAP - 1);

  // Request tracker: IDLE = nothing outstanding, WAIT_RSP = one accepted
  // request whose response has not come back yet.
  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_WAIT_RSP = 1'b1;

  logic              state;
  logic              discard;   // outstanding response belongs to a flushed stream
  logic              post_rst;  // first cycle after reset: no new request
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr;

  logic [DATA_W-1:0] q_data [CAP];
  logic [ADDR_W-1:0] q_pc   [CAP];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic rsp_in;
  logic push;
  logic pop;
  logic accept;
  logic empty;
  logic has_room;

  // Handshake decode. A returning response frees the tracker this cycle, so
  // a new request may go out alongside it if the queue will still have room.
  always_comb begin
    rsp_in   = (state == ST_WAIT_RSP) && fetch_valid;
    empty    = (count == '0);
    push     = rsp_in && !discard && !flush;
    pop      = !empty && !stall && !flush;
    has_room = push ? (count < CNT_CAP_1) : (count < CNT_CAP);
    fetch_start = !rst && !post_rst && !flush && has_room &&
                  ((state == ST_IDLE) || rsp_in);
    accept   = fetch_start && fetch_ready;
  end

  // Outputs to memory and decode.
  always_comb begin
    fetch_addr = pc_q;
    dbg_state  = state;
    if (rst || empty) begin
      insn    = `NOP;
      insn_pc = '0;
    end else begin
      insn    = q_data[rd_ptr];
      insn_pc = q_pc[rd_ptr];
    end
  end

  // Request tracker, fetch PC and discard marking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      discard  <= 1'b0;
      post_rst <= 1'b1;
      pc_q     <= ADDR_W'(RESET_PC);
      req_addr <= ADDR_W'(RESET_PC);
    end else begin
      post_rst <= 1'b0;
      if (rsp_in) begin
        state   <= ST_IDLE;
        discard <= 1'b0;
      end else if (flush && (state == ST_WAIT_RSP)) begin
        discard <= 1'b1;
      end
      if (accept) begin
        state    <= ST_WAIT_RSP;
        req_addr <= pc_q;
      end
      if (flush) begin
        pc_q <= target;
      end else if (accept) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  // Queue pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: response data tagged with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= fetch_data;
      q_pc[wr_ptr]   <= req_addr;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: randomized bench for core_fetch with a memory responder,
// a queue-level reference model and a monitor that checks decode outputs.
// Cycle timing: DUT inputs from memory change at posedge+1, control inputs
// at posedge+2, the monitor samples at negedge, the model advances at
// negedge+1 (describing what the next posedge does).

`ifndef NOP
`define NOP 16'h0001
`endif

module tb_core_fetch;
  localparam int DEPTH    = 4;
  localparam int RESET_PC = 0;
  localparam int AW       = 32;
  localparam int DW       = 16;
`ifdef CORE_FETCH_PREFETCH_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic [AW-1:0] target;
  logic          fetch_start;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready, fetch_valid;
  logic [DW-1:0] fetch_data;
  logic [DW-1:0] insn;
  logic [AW-1:0] insn_pc;
  logic          dbg_state;

  always #5 clk = ~clk;

  core_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .target(target),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .insn(insn), .insn_pc(insn_pc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW+AW-1:0] exp_q[$];   // {data, pc} expected in the DUT queue, oldest first

  logic [AW-1:0] exp_pc;
  bit            mem_busy = 0;
  bit            mem_discard = 0;
  logic [AW-1:0] mem_addr = '0;
  int            mem_lat = 0;
  bit            nv_valid = 0;
  bit            nv_ready = 0;
  logic [DW-1:0] nv_data = '0;
  int            ready_pct = 100;
  int            lat_max = 0;
  int            n_acc = 0;
  int            n_pops = 0;
  int            n_disc = 0;
  bit            rst_prev = 0;
  bit            hold_prev = 0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory driver ----------------
  // Applies the memory outputs prepared by the model for this cycle.
  always @(posedge clk) begin
    #1;
    fetch_valid = nv_valid;
    fetch_data  = nv_data;
    fetch_ready = nv_ready;
  end

  // ---------------- reference model ----------------
  always @(negedge clk) begin
    bit resp, acc;
    #1;
    resp = fetch_valid;
    acc  = fetch_start && fetch_ready;
    if (rst) begin
      exp_q.delete();
      exp_pc = AW'(RESET_PC);
      if (mem_busy && !resp) begin
        mem_discard = 1;    // pre-reset request answers right after reset
        mem_lat = 0;
      end else begin
        mem_busy = 0;
      end
    end else begin
      if (resp) begin
        if (flush || mem_discard) n_disc++;
        else exp_q.push_back({fetch_data, mem_addr});
        mem_busy = 0;
        mem_discard = 0;
      end
      if (flush) begin
        exp_q.delete();
        exp_pc = target;
        if (mem_busy) mem_discard = 1;
      end
      if (acc) begin
        check("one_outstanding", mem_busy, 0);
        check("fetch_addr", fetch_addr, exp_pc);
        mem_busy    = 1;
        mem_discard = 0;
        mem_addr    = fetch_addr;
        mem_lat     = $urandom_range(0, lat_max);
        exp_pc      = exp_pc + 1;
        n_acc++;
      end
    end
    nv_valid = mem_busy && (mem_lat == 0);
    if (mem_busy && mem_lat > 0) mem_lat--;
    nv_data  = DW'($urandom_range(0, 16'hFFFF));
    nv_ready = ($urandom_range(1, 100) <= ready_pct);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit must_idle;
    if (!rst) begin
      if (exp_q.size() == 0) begin
        check("insn_empty", insn, `NOP);
        check("insn_pc_empty", insn_pc, 0);
      end else begin
        check("insn", insn, exp_q[0][DW+AW-1:AW]);
        check("insn_pc", insn_pc, exp_q[0][AW-1:0]);
      end
    end
    must_idle = rst || rst_prev || flush || (mem_busy && !fetch_valid) ||
                ((exp_q.size() + ((mem_busy && !mem_discard) ? 1 : 0)) >= CAP);
    if (must_idle) check("fetch_start_low", fetch_start, 0);
    if (hold_prev && !rst && !flush) begin
      check("fetch_start_hold", fetch_start, 1);
      check("fetch_addr_hold", fetch_addr, prev_addr);
    end
    hold_prev = fetch_start && !fetch_ready;
    prev_addr = fetch_addr;
    rst_prev  = rst;
    if (!rst && !flush && !stall && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_pops++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int a0, k;
    rst = 1; stall = 0; flush = 0; target = '0;
    fetch_valid = 0; fetch_ready = 0; fetch_data = '0;
    exp_pc = AW'(RESET_PC);
    repeat (3) step();
    rst = 0;

    // Streaming with an always-ready, 1-cycle memory.
    ready_pct = 100; lat_max = 0;
    a0 = n_pops;
    repeat (20) step();
    check("basic_progress", (n_pops - a0) >= 4, 1);

    // Held stall from an empty queue: exactly CAP requests fill it.
    lat_max = 2;
    stall = 1; flush = 1; target = '0;
    step();
    flush = 0;
    a0 = n_acc;
    repeat (20) step();
    check("stall_fill_count", n_acc - a0, CAP);
    check("stall_queue_full", exp_q.size(), CAP);
    stall = 0;
    a0 = n_acc;
    repeat (20) step();
    check("resume_after_stall", (n_acc - a0) > 0, 1);

    // Flush while a request is accepted but unanswered.
    k = 0;
    while (!(mem_busy && !mem_discard && !fetch_valid) && k < 100) begin step(); k++; end
    check("wait_outstanding", k < 100, 1);
    a0 = n_disc;
    flush = 1; target = 32'h40;
    step();
    flush = 0;
    repeat (10) step();
    check("flush_discard_seen", n_disc > a0, 1);

    // Flush in the same cycle as a response.
    k = 0;
    while (!(fetch_valid && !mem_discard) && k < 100) begin step(); k++; end
    check("wait_response", k < 100, 1);
    a0 = n_disc;
    flush = 1; target = 32'h80;
    step();
    flush = 0;
    check("flush_same_cycle_drop", n_disc > a0, 1);
    repeat (10) step();

    // Reset mid-stream with entries queued.
    stall = 1;
    k = 0;
    while (exp_q.size() < ((CAP < 3) ? CAP : 3) && k < 100) begin step(); k++; end
    check("wait_queue_fill", k < 100, 1);
    rst = 1;
    step();
    rst = 0; stall = 0;
    a0 = n_acc;
    repeat (10) step();
    check("restart_after_reset", (n_acc - a0) > 0, 1);

    // Randomized traffic.
    ready_pct = 70;
    for (int i = 0; i < 800; i++) begin
      stall  = ($urandom_range(0, 99) < 30);
      flush  = ($urandom_range(0, 99) < 4);
      target = AW'($urandom_range(0, 255));
      rst    = ($urandom_range(0, 199) == 0);
      step();
    end
    stall = 0; flush = 0; rst = 0;
    repeat (20) step();
    check("progress_total", n_pops > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
